// File: rtl/hmc_mem_link_init.sv
// Memory-side HMC link initialization FSM: power-state handshake, NULL/TS1 training
// sequence, sleep/wake and fatal-error reporting toward the link controller.
module hmc_mem_link_init #(
    parameter int unsigned DWIDTH        = 256,
    parameter int unsigned NUM_LANES     = 8,
    parameter int unsigned T_RESP1_CYC   = 16,
    parameter int unsigned T_RESP2_CYC   = 8,
    parameter logic [31:0] TS1_WORD      = 32'hF0C0_F0C1,
    parameter int unsigned TS1_MATCH     = 4,
    parameter int unsigned T_TS1_TIMEOUT = 256
) (
    input  logic              hmc_clk,
    input  logic              hmc_res,
    input  logic              P_RST_N,
    input  logic              LXRXPS,
    input  logic [DWIDTH-1:0] phy_data_tx_link2phy,
    output logic              LXTXPS,
    output logic              FERR_N,
    output logic [DWIDTH-1:0] phy_data_rx_phy2link,
    output logic              link_up,
    output logic [2:0]        state_o
);

    localparam int unsigned LANE_W  = DWIDTH / NUM_LANES;
    localparam int unsigned MAX_12  = (T_RESP1_CYC > T_RESP2_CYC) ? T_RESP1_CYC : T_RESP2_CYC;
    localparam int unsigned MAX_T   = (MAX_12 > T_TS1_TIMEOUT) ? MAX_12 : T_TS1_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(MAX_T + 1);
    localparam int unsigned MATCH_W = $clog2(TS1_MATCH + 1);

    localparam logic [DWIDTH-1:0] TS1_PAT = {NUM_LANES{LANE_W'(TS1_WORD)}};

    typedef enum logic [2:0] {
        ST_RESET   = 3'd0,
        ST_WAIT_PS = 3'd1,
        ST_NULL1   = 3'd2,
        ST_TS1     = 3'd3,
        ST_NULL2   = 3'd4,
        ST_ACTIVE  = 3'd5,
        ST_SLEEP   = 3'd6,
        ST_ERROR   = 3'd7
    } state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [MATCH_W-1:0] match, match_nx;
    logic               lxtxps_nx, ferr_n_nx, link_up_nx;
    logic [DWIDTH-1:0]  data_nx;
    logic               tx_match;

    assign tx_match = (phy_data_tx_link2phy == TS1_PAT);

    // Next state, counters, and next-output values derived from the next state so that
    // registered outputs always line up with the registered state.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        match_nx   = match;
        lxtxps_nx  = 1'b0;
        ferr_n_nx  = 1'b1;
        link_up_nx = 1'b0;
        data_nx    = '0;

        case (state)
            ST_RESET: begin
                if (P_RST_N) state_nx = ST_WAIT_PS;
            end
            ST_WAIT_PS: begin
                if (LXRXPS) state_nx = ST_NULL1;
            end
            ST_NULL1: begin
                cnt_nx = cnt + CNT_W'(1);
                if (cnt == CNT_W'(T_RESP1_CYC - 1)) state_nx = ST_TS1;
            end
            ST_TS1: begin
                cnt_nx = cnt + CNT_W'(1);
                if (!tx_match)
                    match_nx = '0;
                else if (match != MATCH_W'(TS1_MATCH))
                    match_nx = match + MATCH_W'(1);
                // A match completing on the timeout cycle still wins.
                if (match_nx == MATCH_W'(TS1_MATCH))
                    state_nx = ST_NULL2;
                else if (cnt == CNT_W'(T_TS1_TIMEOUT - 1))
                    state_nx = ST_ERROR;
            end
            ST_NULL2: begin
                cnt_nx = cnt + CNT_W'(1);
                if (cnt == CNT_W'(T_RESP2_CYC - 1)) state_nx = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (!LXRXPS) state_nx = ST_SLEEP;
            end
            ST_SLEEP: begin
                if (LXRXPS) state_nx = ST_NULL1;
            end
            ST_ERROR: begin
                state_nx = ST_ERROR;
            end
            default: state_nx = ST_RESET;
        endcase

        // Controller power-down during training, then controller reset, take priority.
        if (!LXRXPS && (state == ST_NULL1 || state == ST_TS1 || state == ST_NULL2))
            state_nx = ST_WAIT_PS;
        if (!P_RST_N && state != ST_RESET)
            state_nx = ST_RESET;

        if (state_nx != state) begin
            cnt_nx   = '0;
            match_nx = '0;
        end

        case (state_nx)
            ST_NULL1, ST_NULL2: lxtxps_nx = 1'b1;
            ST_TS1: begin
                lxtxps_nx = 1'b1;
                data_nx   = TS1_PAT;
            end
            ST_ACTIVE: begin
                lxtxps_nx  = 1'b1;
                link_up_nx = 1'b1;
            end
            ST_ERROR: ferr_n_nx = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge hmc_clk) begin
        if (hmc_res) begin
            state                <= ST_RESET;
            cnt                  <= '0;
            match                <= '0;
            LXTXPS               <= 1'b0;
            FERR_N               <= 1'b1;
            link_up              <= 1'b0;
            phy_data_rx_phy2link <= '0;
        end else begin
            state                <= state_nx;
            cnt                  <= cnt_nx;
            match                <= match_nx;
            LXTXPS               <= lxtxps_nx;
            FERR_N               <= ferr_n_nx;
            link_up              <= link_up_nx;
            phy_data_rx_phy2link <= data_nx;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_hmc_mem_link_init.sv
// Directed bench for hmc_mem_link_init: training, broken match, timeout,
// match-on-timeout boundary, sleep/wake and reset aborts.
module tb_hmc_mem_link_init;

    localparam int unsigned DW = 256;

    logic          clk = 1'b0;
    logic          hmc_res;
    logic          p_rst_n;
    logic          lxrxps;
    logic [DW-1:0] tx;
    logic          lxtxps;
    logic          ferr_n;
    logic [DW-1:0] rx;
    logic          link_up;
    logic [2:0]    state_o;

    logic [DW-1:0] pat;
    int            total = 0;
    int            bad   = 0;

    always #5 clk = ~clk;

    hmc_mem_link_init dut (
        .hmc_clk              (clk),
        .hmc_res              (hmc_res),
        .P_RST_N              (p_rst_n),
        .LXRXPS               (lxrxps),
        .phy_data_tx_link2phy (tx),
        .LXTXPS               (lxtxps),
        .FERR_N               (ferr_n),
        .phy_data_rx_phy2link (rx),
        .link_up              (link_up),
        .state_o              (state_o)
    );

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_outs(input string tag, input logic [2:0] st, input logic txps,
                            input logic fe, input logic lu, input logic [DW-1:0] d);
        chk({tag, ".state"},  DW'(state_o), DW'(st));
        chk({tag, ".lxtxps"}, DW'(lxtxps),  DW'(txps));
        chk({tag, ".ferr_n"}, DW'(ferr_n),  DW'(fe));
        chk({tag, ".link_up"},DW'(link_up), DW'(lu));
        chk({tag, ".data"},   rx, d);
    endtask

    initial begin
        for (int l = 0; l < 8; l++) pat[l*32 +: 32] = 32'hF0C0_F0C1;
        hmc_res = 1'b1; p_rst_n = 1'b0; lxrxps = 1'b0; tx = '0;
        step(2);
        chk_outs("reset", 3'd0, 1'b0, 1'b1, 1'b0, '0);

        // Nominal training
        hmc_res = 1'b0; p_rst_n = 1'b1; lxrxps = 1'b1;
        step(1);  chk("nom_wait_ps", DW'(state_o), DW'(3'd1));
        step(1);  chk_outs("nom_null1_first", 3'd2, 1'b1, 1'b1, 1'b0, '0);
        step(15); chk("nom_null1_last", DW'(state_o), DW'(3'd2));
        step(1);  chk_outs("nom_ts1_first", 3'd3, 1'b1, 1'b1, 1'b0, pat);
        step(3);  tx = pat;                  // TS1 cycle 4: controller starts echoing
        step(3);  chk("nom_ts1_cyc7", DW'(state_o), DW'(3'd3));
        step(1);  chk_outs("nom_null2_first", 3'd4, 1'b1, 1'b1, 1'b0, '0);
        step(7);  chk("nom_null2_last", DW'(state_o), DW'(3'd4));
        step(1);  chk_outs("nom_active", 3'd5, 1'b1, 1'b1, 1'b1, '0);

        // Sleep / wake, then broken-match retraining
        lxrxps = 1'b0;
        step(1);  chk_outs("sleep", 3'd6, 1'b0, 1'b1, 1'b0, '0);
        step(2);  chk("sleep_hold", DW'(state_o), DW'(3'd6));
        lxrxps = 1'b1;
        step(1);  chk_outs("wake_null1", 3'd2, 1'b1, 1'b1, 1'b0, '0);
        step(15); chk("wake_null1_last", DW'(state_o), DW'(3'd2));
        step(1);  chk("brk_ts1_first", DW'(state_o), DW'(3'd3));
        step(3);  chk("brk_ts1_cyc4", DW'(state_o), DW'(3'd3));
        tx = pat ^ DW'(1);
        step(1);  chk("brk_ts1_cyc5", DW'(state_o), DW'(3'd3));
        tx = pat;
        step(3);  chk("brk_ts1_cyc8", DW'(state_o), DW'(3'd3));
        step(1);  chk("brk_null2", DW'(state_o), DW'(3'd4));

        // Power-down during NULL2, then timeout to ERROR
        lxrxps = 1'b0; tx = '0;
        step(1);  chk_outs("drop_wait_ps", 3'd1, 1'b0, 1'b1, 1'b0, '0);
        lxrxps = 1'b1;
        step(1);  chk("to_null1", DW'(state_o), DW'(3'd2));
        step(16); chk("to_ts1_first", DW'(state_o), DW'(3'd3));
        step(255);chk("to_ts1_cyc256", DW'(state_o), DW'(3'd3));
        step(1);  chk_outs("to_error", 3'd7, 1'b0, 1'b0, 1'b0, '0);
        step(3);  chk("err_hold", DW'(state_o), DW'(3'd7));
        p_rst_n = 1'b0;
        step(1);  chk_outs("err_prst", 3'd0, 1'b0, 1'b1, 1'b0, '0);
        p_rst_n = 1'b1;
        step(1);  chk("rec_wait_ps", DW'(state_o), DW'(3'd1));

        // Match completing on the timeout cycle wins over ERROR
        step(1);  chk("mot_null1", DW'(state_o), DW'(3'd2));
        step(16); chk("mot_ts1_first", DW'(state_o), DW'(3'd3));
        step(252);
        tx = pat;                            // TS1 cycles 253..256 match
        step(3);  chk("mot_ts1_cyc256", DW'(state_o), DW'(3'd3));
        step(1);  chk_outs("mot_null2", 3'd4, 1'b1, 1'b1, 1'b0, '0);

        // P_RST_N abort in cycle 5 of NULL1
        lxrxps = 1'b0; tx = '0;
        step(1);  chk("ab_wait_ps", DW'(state_o), DW'(3'd1));
        lxrxps = 1'b1;
        step(1);  chk("ab_null1", DW'(state_o), DW'(3'd2));
        step(4);
        p_rst_n = 1'b0;
        step(1);  chk_outs("ab_prst", 3'd0, 1'b0, 1'b1, 1'b0, '0);
        p_rst_n = 1'b1;
        step(1);  chk("ab2_wait_ps", DW'(state_o), DW'(3'd1));
        step(1);  chk("ab2_null1", DW'(state_o), DW'(3'd2));
        step(16); chk_outs("ab2_ts1", 3'd3, 1'b1, 1'b1, 1'b0, pat);

        // hmc_res abort in TS1
        hmc_res = 1'b1;
        step(1);  chk_outs("ab_hmc_res", 3'd0, 1'b0, 1'b1, 1'b0, '0);
        hmc_res = 1'b0;
        step(1);  chk("post_res_wait_ps", DW'(state_o), DW'(3'd1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hmc_mem_link_init.md
HMC_MEM_LINK_INIT -- requirements
Module: hmc_mem_link_init

Interface
REQ-001 SHALL have parameter DWIDTH, default 256, width of PHY data buses.
REQ-002 SHALL have parameter NUM_LANES, default 8; lane slice = DWIDTH/NUM_LANES bits, lane 0 in the LSBs.
REQ-003 SHALL have parameter T_RESP1_CYC, default 16, duration of NULL1 in cycles (tRESP1 scaled).
REQ-004 SHALL have parameter T_RESP2_CYC, default 8, duration of NULL2 in cycles (tRESP2 scaled).
REQ-005 SHALL have parameter TS1_WORD, default 32'hF0C0_F0C1, per-lane training pattern.
REQ-006 SHALL have parameter TS1_MATCH, default 4, consecutive controller TS1 cycles required.
REQ-007 SHALL have parameter T_TS1_TIMEOUT, default 256, TS1 wait limit in cycles.
REQ-008 hmc_clk  in  1  single clock; all logic rising-edge.
REQ-009 hmc_res  in  1  reset, synchronous, active-high.
REQ-010 P_RST_N  in  1  HMC reset from controller, active-low.
REQ-011 LXRXPS  in  1  controller power-state request; 1 = active, 0 = sleep.
REQ-012 phy_data_tx_link2phy  in  DWIDTH  controller-transmitted data.
REQ-013 LXTXPS  out  1  memory power-state acknowledge.
REQ-014 FERR_N  out  1  fatal error, active-low.
REQ-015 phy_data_rx_phy2link  out  DWIDTH  memory-to-controller data.
REQ-016 link_up  out  1  high only in ACTIVE.
REQ-017 state_o  out  3  current state encoding: RESET=0, WAIT_PS=1, NULL1=2, TS1=3, NULL2=4, ACTIVE=5, SLEEP=6, ERROR=7.

Function
REQ-018 RESET: outputs LXTXPS=0, data=0, FERR_N=1; go WAIT_PS the cycle after P_RST_N samples 1.
REQ-019 WAIT_PS: LXTXPS=0, data=0; go NULL1 the cycle after LXRXPS samples 1.
REQ-020 NULL1: LXTXPS=1, data all-zero (null flits) for exactly T_RESP1_CYC cycles, then TS1.
REQ-021 TS1: every lane slice of phy_data_rx_phy2link = TS1_WORD; LXTXPS=1.
REQ-022 TS1 match cycle: every lane slice of phy_data_tx_link2phy equals TS1_WORD; any mismatch clears the match counter to 0.
REQ-023 TS1 -> NULL2 on the cycle the match counter reaches TS1_MATCH (counted from TS1 entry; counter saturates, no wrap).
REQ-024 TS1 timeout: if T_TS1_TIMEOUT cycles elapse in TS1 without reaching TS1_MATCH -> ERROR; match reached on the timeout cycle itself SHALL take NULL2 (match wins).
REQ-025 NULL2: data=0, LXTXPS=1 for exactly T_RESP2_CYC cycles, then ACTIVE.
REQ-026 ACTIVE: link_up=1, data=0 (idle nulls), LXTXPS=1; LXRXPS sampled 0 -> SLEEP.
REQ-027 SLEEP: LXTXPS=0 the first SLEEP cycle, data=0, link_up=0; LXRXPS sampled 1 -> NULL1 (full re-training).
REQ-028 ERROR: FERR_N=0, data=0, LXTXPS=0; held until P_RST_N=0 or hmc_res.
REQ-029 P_RST_N sampled 0 in any state except RESET -> RESET next cycle; FERR_N returns to 1.
REQ-030 LXRXPS sampled 0 during NULL1, TS1 or NULL2 -> WAIT_PS next cycle, counters cleared.
REQ-031 All outputs registered; output values SHALL correspond to the current state (one-cycle state-to-output latency from the transition-causing sample).
REQ-032 Cycle counters SHALL be sized for max(T_RESP1_CYC, T_RESP2_CYC, T_TS1_TIMEOUT) and reloaded on every state entry.
REQ-033 Priority when simultaneous: hmc_res > P_RST_N=0 > LXRXPS=0 > state-internal transitions.

Reset
REQ-034 hmc_res=1 SHALL, at the next edge, force RESET, LXTXPS=0, FERR_N=1, link_up=0, data=0, all counters 0, regardless of state.
REQ-035 Reset asserted mid-training SHALL abort without emitting a partial TS1 cycle after the reset edge.

Verification
REQ-036 Nominal: release reset, P_RST_N=1, LXRXPS=1, controller echoes TS1 from 4th TS1 cycle -> 16 null cycles, TS1 until 4 matches, 8 null cycles, link_up=1.
REQ-037 Broken match: controller sends 3 TS1, 1 corrupt, then 4 TS1 -> counter resets, NULL2 entered only after the second run of 4.
REQ-038 Timeout: controller never sends TS1 -> ERROR after 256 TS1 cycles, FERR_N=0; P_RST_N pulse 0 -> RESET, FERR_N=1.
REQ-039 Sleep/wake: LXRXPS 1->0 in ACTIVE -> SLEEP, LXTXPS=0, link_up=0; LXRXPS 0->1 -> NULL1 for 16 cycles, full re-train.
REQ-040 Abort: P_RST_N=0 in cycle 5 of NULL1, and separately hmc_res=1 in TS1 -> RESET next cycle, all outputs at reset values.
